// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid/ready handshake, optional 2-entry skid
// buffer, flush/squash support and a saturating count of flushed entries.
//
// Ports:
//   clk_i        clock, all state updates on the rising edge
//   clr_i        synchronous active-high reset
//   flush_i      squash held entries and any same-cycle accepted input
//   in_valid_i   upstream payload valid
//   in_ready_o   stage can accept this cycle
//   in_data_i    upstream payload
//   out_valid_o  out_data_o is valid
//   out_ready_i  downstream accepts this cycle
//   out_data_o   payload at head of stage
//   level_o      occupancy 0..2 (at most 1 when SKID=0)
//   drop_cnt_o   saturating count of entries discarded by flush
module pipe_stage_skid #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned SKID    = 1,
  parameter int unsigned CLR_DAT = 1,
  parameter int unsigned CNT_W   = 8
) (
  input  logic              clk_i,
  input  logic              clr_i,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [1:0]        level_o,
  output logic [CNT_W-1:0]  drop_cnt_o
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

  // Two guard bits so level + acc on top of a saturated count cannot wrap.
  localparam int unsigned SUM_W = CNT_W + 2;
  localparam logic [SUM_W-1:0] CNT_MAX = SUM_W'({CNT_W{1'b1}});

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   main_q, main_d;
  logic [DATA_W-1:0]   skid_q, skid_d;
  logic [CNT_W-1:0]    drop_q, drop_d;
  logic [SUM_W-1:0]    drop_sum;
  logic                acc, con;

  // Outputs derived directly from state registers.
  always_comb begin
    out_data_o  = main_q;
    out_valid_o = (state_q != ST_EMPTY);
    drop_cnt_o  = drop_q;
    case (state_q)
      ST_ONE:  level_o = 2'd1;
      ST_TWO:  level_o = 2'd2;
      default: level_o = 2'd0;
    endcase
  end

  // With the skid the ready path is cut from out_ready; without it the
  // single entry can be refilled in the cycle it drains.
  always_comb begin
    if (SKID != 0) in_ready_o = (state_q != ST_TWO) & ~clr_i;
    else           in_ready_o = (~out_valid_o | out_ready_i) & ~clr_i;
  end

  assign acc = in_valid_i & in_ready_o;
  assign con = out_valid_o & out_ready_i;

  // Next-state, payload and drop-counter logic.
  always_comb begin
    state_d  = state_q;
    main_d   = main_q;
    skid_d   = skid_q;
    drop_d   = drop_q;
    // con implies level >= 1, so level - con never underflows.
    drop_sum = SUM_W'(drop_q) + SUM_W'(level_o) - SUM_W'(con) + SUM_W'(acc);

    if (flush_i) begin
      state_d = ST_EMPTY;
      if (CLR_DAT != 0) begin
        main_d = '0;
        skid_d = '0;
      end
      drop_d = (drop_sum > CNT_MAX) ? {CNT_W{1'b1}} : drop_sum[CNT_W-1:0];
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (acc) begin
            state_d = ST_ONE;
            main_d  = in_data_i;
          end
        end
        ST_ONE: begin
          if (acc && con) begin
            main_d = in_data_i;
          end else if (acc && (SKID != 0)) begin
            state_d = ST_TWO;
            skid_d  = in_data_i;
          end else if (con) begin
            state_d = ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (con) begin
            state_d = ST_ONE;
            main_d  = skid_q;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  // State registers; clr_i overrides everything.
  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      state_q <= ST_EMPTY;
      drop_q  <= '0;
      if (CLR_DAT != 0) begin
        main_q <= '0;
        skid_q <= '0;
      end else begin
        main_q <= main_q;
        skid_q <= skid_q;
      end
    end else begin
      state_q <= state_d;
      drop_q  <= drop_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

endmodule
